// File: rtl/spi_pwm_multi_pkg.sv
// Shared constants for the SPI register slave and the multi-channel PWM block.
package spi_pwm_pkg;
  localparam int FRAME_BITS = 16;
  localparam int SYNC_DEPTH = 2;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  localparam logic [6:0] ADDR_EN_OUT0   = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT1   = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM0   = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM1   = 7'h03;
  localparam logic [6:0] ADDR_STATUS    = 7'h04;
  localparam logic [6:0] ADDR_DUTY_BASE = 7'h10;
endpackage

// File: rtl/spi_pwm_multi_if.sv
// SPI mode-0 pad bundle; the controller side drives sclk/copi/ncs, the peripheral drives cipo/cipo_oe.
interface spi_pwm_multi_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
  modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_pwm_multi_frame_rx.sv
// SPI mode-0 frame receiver: synchronisers, edge detection, bit counting,
// read shift-out and one-clk write-commit / frame-error strobes.
module spi_frame_rx
  import spi_pwm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic       cipo_oe,
  output logic [6:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       wr_stb,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       ferr_stb
);
  logic [SYNC_DEPTH:0]   sclk_sync_q, sclk_sync_d, ncs_sync_q, ncs_sync_d;
  logic [SYNC_DEPTH-1:0] copi_sync_q, copi_sync_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_in_q, shift_in_d;
  logic [7:0]            shift_out_q, shift_out_d;
  logic active_q, active_d, rd_pend_q, rd_pend_d, dphase_q, dphase_d;
  logic wr_stb_q, wr_stb_d, ferr_stb_q, ferr_stb_d;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_DEPTH-1:0], sclk};
    ncs_sync_d  = {ncs_sync_q[SYNC_DEPTH-1:0], ncs};
    copi_sync_d = {copi_sync_q[SYNC_DEPTH-2:0], copi};
    sclk_rise   = sclk_sync_q[SYNC_DEPTH-1] & ~sclk_sync_q[SYNC_DEPTH];
    sclk_fall   = ~sclk_sync_q[SYNC_DEPTH-1] & sclk_sync_q[SYNC_DEPTH];
    ncs_rise    = ncs_sync_q[SYNC_DEPTH-1] & ~ncs_sync_q[SYNC_DEPTH];
    ncs_fall    = ~ncs_sync_q[SYNC_DEPTH-1] & ncs_sync_q[SYNC_DEPTH];

    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    active_d    = active_q;
    dphase_d    = dphase_q;
    rd_pend_d   = 1'b0;
    wr_stb_d    = 1'b0;
    ferr_stb_d  = 1'b0;

    if (ncs_fall) begin
      active_d  = 1'b1;
      bit_cnt_d = '0;
      dphase_d  = 1'b0;
    end else if (ncs_rise) begin
      active_d = 1'b0;
      dphase_d = 1'b0;
      if (active_q) begin
        if (bit_cnt_q == CNT_FULL) wr_stb_d = ~shift_in_q[FRAME_BITS-1];
        else if (bit_cnt_q != '0) ferr_stb_d = 1'b1;
      end
    end else if (active_q) begin
      if (sclk_rise) begin
        shift_in_d = {shift_in_q[FRAME_BITS-2:0], copi_sync_q[SYNC_DEPTH-1]};
        if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 5'd1;
        rd_pend_d = (bit_cnt_q == 5'd7);
        if (bit_cnt_q == 5'd15) dphase_d = 1'b0;
      end
      if (rd_pend_q && shift_in_q[7]) begin
        shift_out_d = rd_data;
        dphase_d    = 1'b1;
      end
      // MSB is held through the 9th rise; later falls advance to the next bit.
      if (sclk_fall && dphase_q && bit_cnt_q >= 5'd9) shift_out_d = {shift_out_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '0;
      copi_sync_q <= '0;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      active_q    <= 1'b0;
      dphase_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      wr_stb_q    <= 1'b0;
      ferr_stb_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      copi_sync_q <= copi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      active_q    <= active_d;
      dphase_q    <= dphase_d;
      rd_pend_q   <= rd_pend_d;
      wr_stb_q    <= wr_stb_d;
      ferr_stb_q  <= ferr_stb_d;
    end
  end

  assign cipo     = dphase_q & shift_out_q[7];
  assign cipo_oe  = active_q;
  assign rd_addr  = shift_in_q[6:0];
  assign wr_stb   = wr_stb_q;
  assign wr_addr  = shift_in_q[14:8];
  assign wr_data  = shift_in_q[7:0];
  assign ferr_stb = ferr_stb_q;
endmodule

// File: rtl/spi_pwm_multi.sv
// Multi-channel PWM peripheral: SPI register file, shadowed duty registers,
// shared prescaler/counter timebase and registered per-channel outputs.
module spi_pwm_multi
  import spi_pwm_pkg::*;
#(
  parameter int NCH     = 16,
  parameter int DUTY_W  = 8,
  parameter int CLK_DIV = 3333
) (
  input  logic               clk,
  input  logic               rst,
  spi_pwm_multi_if.slave     spi,
  output logic [NCH-1:0]     out,
  output logic               frame_err
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [DUTY_W-1:0] CNT_LAST   = DUTY_W'((1 << DUTY_W) - 2);
  localparam logic [DUTY_W-1:0] DUTY_FULL  = '1;
  localparam logic [15:0]       CH_MASK    = 16'((32'd1 << NCH) - 32'd1);

  logic [15:0]       en_out_q, en_out_d, en_pwm_q, en_pwm_d;
  logic              ferr_q, ferr_d;
  logic [DUTY_W-1:0] shadow_q [NCH];
  logic [DUTY_W-1:0] shadow_d [NCH];
  logic [DUTY_W-1:0] active_q [NCH];
  logic [DUTY_W-1:0] active_d [NCH];
  logic [PW-1:0]     presc_q, presc_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]    out_q, out_d;
  logic [6:0]        rd_addr, wr_addr;
  logic [7:0]        rd_data, wr_data;
  logic              wr_stb, ferr_stb, tick, wrap;

  spi_frame_rx u_rx (
    .clk, .rst,
    .sclk(spi.sclk), .copi(spi.copi), .ncs(spi.ncs),
    .cipo(spi.cipo), .cipo_oe(spi.cipo_oe),
    .rd_addr, .rd_data, .wr_stb, .wr_addr, .wr_data, .ferr_stb
  );

  always_comb begin
    en_out_d = en_out_q;
    en_pwm_d = en_pwm_q;
    ferr_d   = ferr_q;
    shadow_d = shadow_q;
    if (wr_stb) begin
      case (wr_addr)
        ADDR_EN_OUT0: en_out_d[7:0]  = wr_data & CH_MASK[7:0];
        ADDR_EN_OUT1: en_out_d[15:8] = wr_data & CH_MASK[15:8];
        ADDR_EN_PWM0: en_pwm_d[7:0]  = wr_data & CH_MASK[7:0];
        ADDR_EN_PWM1: en_pwm_d[15:8] = wr_data & CH_MASK[15:8];
        ADDR_STATUS:  if (wr_data[0]) ferr_d = 1'b0;
        default: ;
      endcase
      for (int ch = 0; ch < NCH; ch++)
        if (wr_addr == ADDR_DUTY_BASE + 7'(ch)) shadow_d[ch] = wr_data[DUTY_W-1:0];
    end
    if (ferr_stb) ferr_d = 1'b1;
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_EN_OUT0: rd_data = en_out_q[7:0];
      ADDR_EN_OUT1: rd_data = en_out_q[15:8];
      ADDR_EN_PWM0: rd_data = en_pwm_q[7:0];
      ADDR_EN_PWM1: rd_data = en_pwm_q[15:8];
      ADDR_STATUS:  rd_data = {7'b0, ferr_q};
      default: ;
    endcase
    for (int ch = 0; ch < NCH; ch++)
      if (rd_addr == ADDR_DUTY_BASE + 7'(ch)) rd_data = 8'(shadow_q[ch]);
  end

  // Active duties only change on the counter wrap so a period is never cut short.
  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    wrap     = tick && (cnt_q == CNT_LAST);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    cnt_d    = !tick ? cnt_q : (wrap ? '0 : cnt_q + 1'b1);
    active_d = wrap ? shadow_q : active_q;
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic pwm;
    assign pwm       = (cnt_q < active_q[ch]) || (active_q[ch] == DUTY_FULL);
    assign out_d[ch] = en_out_q[ch] & (en_pwm_q[ch] ? pwm : 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_out_q <= '0;
      en_pwm_q <= '0;
      ferr_q   <= 1'b0;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      presc_q  <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      en_out_q <= en_out_d;
      en_pwm_q <= en_pwm_d;
      ferr_q   <= ferr_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign out       = out_q;
  assign frame_err = ferr_q;
endmodule

// File: tb/tb_spi_pwm_multi.sv
// Directed + randomized bench for spi_pwm_multi against a register/duty-cycle model.
module tb_spi_pwm_multi;
  localparam int NCH     = 16;
  localparam int DUTY_W  = 8;
  localparam int CLK_DIV = 4;
  localparam int H       = 8;
  localparam int PERIOD  = 255 * CLK_DIV;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] out;
  logic           frame_err;
  int             cyc = 0;
  int             vectors = 0;
  int             errors = 0;
  int             hi_cnt [NCH];

  spi_pwm_multi_if bus ();

  spi_pwm_multi #(.NCH(NCH), .DUTY_W(DUTY_W), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .spi(bus), .out(out), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [15:0] m_en_out, m_en_pwm;
  logic [7:0]  m_duty [NCH];
  logic        m_ferr;

  task automatic m_reset();
    m_en_out = '0; m_en_pwm = '0; m_ferr = 1'b0;
    for (int c = 0; c < NCH; c++) m_duty[c] = '0;
  endtask

  task automatic m_write(input logic [6:0] a, input logic [7:0] d);
    int ia;
    ia = int'(a);
    if (ia == 0) m_en_out[7:0] = d;
    else if (ia == 1) m_en_out[15:8] = d;
    else if (ia == 2) m_en_pwm[7:0] = d;
    else if (ia == 3) m_en_pwm[15:8] = d;
    else if (ia == 4) begin if (d[0]) m_ferr = 1'b0; end
    else if (ia >= 16 && ia < 16 + NCH) m_duty[ia-16] = d;
  endtask

  function automatic logic [7:0] m_read(input logic [6:0] a);
    int ia;
    ia = int'(a);
    if (ia == 0) return m_en_out[7:0];
    if (ia == 1) return m_en_out[15:8];
    if (ia == 2) return m_en_pwm[7:0];
    if (ia == 3) return m_en_pwm[15:8];
    if (ia == 4) return {7'b0, m_ferr};
    if (ia >= 16 && ia < 16 + NCH) return m_duty[ia-16];
    return 8'h00;
  endfunction

  // Clock cycles high in a window of whole PWM periods.
  function automatic int exp_hi(input int c, input int nper);
    if (!m_en_out[c]) return 0;
    if (!m_en_pwm[c] || m_duty[c] == 8'hFF) return PERIOD * nper;
    return int'(m_duty[c]) * CLK_DIV * nper;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic spi_begin();
    @(negedge clk); bus.ncs = 1'b0; bus.sclk = 1'b0;
    clks(H);
    @(negedge clk);
    check("cipo_oe_in_frame", 32'(bus.cipo_oe), 32'd1);
  endtask

  task automatic spi_shift(input logic [15:0] frame, input int nbits, output logic [7:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); bus.copi = (i < 16) ? frame[15-i] : 1'b0;
      clks(H);
      @(negedge clk);
      if (i >= 8 && i < 16) rd[15-i] = bus.cipo;
      bus.sclk = 1'b1;
      clks(H);
      @(negedge clk); bus.sclk = 1'b0;
    end
  endtask

  task automatic spi_end();
    clks(H);
    @(negedge clk); bus.ncs = 1'b1;
    clks(6);
    @(negedge clk);
    check("cipo_oe_idle", 32'(bus.cipo_oe), 32'd0);
    check("cipo_idle", 32'(bus.cipo), 32'd0);
  endtask

  task automatic spi_xfer(input logic [15:0] frame, input int nbits, output logic [7:0] rd);
    spi_begin();
    spi_shift(frame, nbits, rd);
    spi_end();
  endtask

  task automatic reg_wr(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    spi_xfer({1'b0, a, d}, 16, dummy);
    m_write(a, d);
  endtask

  task automatic reg_rd_check(input logic [6:0] a);
    logic [7:0] rd;
    spi_xfer({1'b1, a, 8'h00}, 16, rd);
    check($sformatf("read_%02h", a), 32'(rd), 32'(m_read(a)));
  endtask

  task automatic measure(input string tag, input int nper);
    for (int c = 0; c < NCH; c++) hi_cnt[c] = 0;
    repeat (PERIOD * nper) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) if (out[c]) hi_cnt[c]++;
    end
    for (int c = 0; c < NCH; c++)
      check($sformatf("%s_ch%0d", tag, c), 32'(hi_cnt[c]), 32'(exp_hi(c, nper)));
  endtask

  task automatic wait_out0(input logic lvl, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (out[0] === lvl) begin at = cyc; break; end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rd, d;
    int t_fall, t_rise, t_fall2, pick;
    bus.ncs = 1'b1; bus.sclk = 1'b0; bus.copi = 1'b0;
    m_reset();

    // reset state
    clks(3);
    @(negedge clk);
    check("rst_out", 32'(out), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_cipo", 32'(bus.cipo), 32'd0);
    check("rst_cipo_oe", 32'(bus.cipo_oe), 32'd0);
    rst = 1'b0;
    clks(8);
    @(negedge clk);
    check("post_rst_ferr", 32'(frame_err), 32'd0);

    // static enables
    reg_wr(7'h00, 8'hFF);
    reg_wr(7'h02, 8'h00);
    check("static_out", 32'(out), 32'h00FF);

    // single PWM channel at half duty
    reg_wr(7'h00, 8'h01);
    reg_wr(7'h02, 8'h01);
    reg_wr(7'h10, 8'h80);
    clks(PERIOD + 20);
    measure("duty80", 2);

    // duty extremes
    reg_wr(7'h10, 8'h00);
    clks(PERIOD + 20);
    measure("duty00", 1);
    reg_wr(7'h10, 8'hFF);
    clks(PERIOD + 20);
    measure("dutyFF", 1);

    // mid-period update must wait for the wrap
    reg_wr(7'h10, 8'h40);
    clks(PERIOD + 20);
    wait_out0(1'b1, 2 * PERIOD, t_rise);
    wait_out0(1'b0, 2 * PERIOD, t_fall);
    reg_wr(7'h10, 8'hC0);
    wait_out0(1'b1, 2 * PERIOD, t_rise);
    check("shadow_low_len", 32'(t_rise - t_fall), 32'((255 - 64) * CLK_DIV));
    wait_out0(1'b0, 2 * PERIOD, t_fall2);
    check("new_high_len", 32'(t_fall2 - t_rise), 32'(192 * CLK_DIV));

    // readback
    reg_wr(7'h13, 8'h5A);
    spi_xfer(16'h9300, 16, rd);
    check("read_duty3_const", 32'(rd), 32'h5A);
    reg_rd_check(7'h13);
    reg_rd_check(7'h7F);
    reg_rd_check(7'h00);

    // short and long frames
    spi_xfer(16'h0000, 12, rd);
    check("ferr_short", 32'(frame_err), 32'd1);
    m_ferr = 1'b1;
    reg_rd_check(7'h00);
    reg_rd_check(7'h04);
    reg_wr(7'h04, 8'h01);
    check("ferr_clear", 32'(frame_err), 32'd0);
    spi_xfer(16'h0055, 20, rd);
    check("ferr_long", 32'(frame_err), 32'd1);
    m_ferr = 1'b1;
    reg_rd_check(7'h00);
    reg_wr(7'h04, 8'h01);
    check("ferr_clear2", 32'(frame_err), 32'd0);

    // reset mid-frame and mid-period
    spi_xfer(16'h0000, 5, rd);
    m_ferr = 1'b1;
    reg_wr(7'h00, 8'hFF);
    spi_begin();
    spi_shift(16'h0123, 5, rd);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    m_reset();
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_cipo_oe", 32'(bus.cipo_oe), 32'd0);
    check("midrst_cipo", 32'(bus.cipo), 32'd0);
    check("midrst_ferr", 32'(frame_err), 32'd0);
    clks(2);
    @(negedge clk); rst = 1'b0;
    spi_shift(16'h00FF, 16, rd);
    clks(H);
    @(negedge clk); bus.ncs = 1'b1;
    clks(8);
    @(negedge clk);
    check("stale_frame_ferr", 32'(frame_err), 32'd0);
    reg_rd_check(7'h00);
    reg_wr(7'h00, 8'hA5);
    check("post_rst_write", 32'(out), 32'(m_en_out & ~m_en_pwm));
    reg_rd_check(7'h00);

    // randomized register programming against the model
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < 4; a++) reg_wr(7'(a), 8'($urandom_range(0, 255)));
      for (int c = 0; c < NCH; c++) begin
        pick = $urandom_range(0, 3);
        d = (pick == 0) ? 8'h00 : (pick == 1) ? 8'hFF : 8'($urandom_range(1, 254));
        reg_wr(7'(16 + c), d);
      end
      reg_wr(7'($urandom_range(32, 127)), 8'($urandom_range(0, 255)));
      reg_wr(7'($urandom_range(5, 15)), 8'($urandom_range(0, 255)));
      for (int k = 0; k < 4; k++) reg_rd_check(7'($urandom_range(0, 127)));
      reg_rd_check(7'($urandom_range(16, 16 + NCH - 1)));
      clks(PERIOD + 20);
      measure($sformatf("rand%0d", r), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
